// File: rtl/rv_decode_pkg.sv
// Shared types and constants for the IF/ID decode skid stage: opcode map,
// instruction-type codes, held-entry layout and skid-buffer states.
package rv_decode_pkg;

  localparam int DEC_XLEN = 32;

  typedef enum logic [2:0] {
    R_NONE = 3'b000,
    I_T    = 3'b001,
    S_T    = 3'b010,
    B_T    = 3'b011,
    U_T    = 3'b100,
    J_T    = 3'b101
  } instr_type_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [DEC_XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [DEC_XLEN-1:0] instr;
    logic [DEC_XLEN-1:0] pc;
    instr_type_e         itype;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                illegal;
  } dec_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/decode_skid_stage_if.sv
// Fetch-side and decode-side handshake bundle of the decode skid stage.
// master drives instructions in and accepts decoded heads; slave is the stage.
interface decode_skid_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_type;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_type,
           out_rs1, out_rs2, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_type,
           out_rs1, out_rs2, out_rd, out_illegal
  );
endinterface

// File: rtl/opcode_classify.sv
// Combinational opcode classifier: maps instr[6:0] to the sign-extender
// type code and flags opcodes outside the supported RV32I set.
module opcode_classify
  import rv_decode_pkg::*;
(
  input  logic [DEC_XLEN-1:0] instr,
  output instr_type_e         itype,
  output logic                illegal
);

  // Only the opcode field matters here; the rest of the word is decoded elsewhere.
  logic [DEC_XLEN-8:0] unused_upper;
  assign unused_upper = instr[DEC_XLEN-1:7];

  always_comb begin
    itype   = R_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OP_REG:                                         itype = R_NONE;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:  itype = I_T;
      OP_STORE:                                       itype = S_T;
      OP_BRANCH:                                      itype = B_T;
      OP_LUI, OP_AUIPC:                               itype = U_T;
      OP_JAL:                                         itype = J_T;
      default: begin
        itype   = R_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_skid_stage.sv
// IF/ID stage with a 2-entry skid buffer so in_ready is purely registered.
// Optional macro DECODE_ILLEGAL_TRAP_EN: report illegal heads and stall fetch behind them.
module decode_skid_stage
  import rv_decode_pkg::*;
#(
  parameter int              XLEN     = DEC_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  decode_skid_stage_if.slave  bus
);

  localparam dec_entry_t RESET_ENTRY = '{
    instr:   NOP,
    pc:      RESET_PC,
    itype:   I_T,
    rs1:     5'd0,
    rs2:     5'd0,
    rd:      5'd0,
    illegal: 1'b0
  };

  skid_state_e state_q, state_d;
  dec_entry_t  head_q, head_d, skid_q, skid_d, entry_in;
  logic        in_ready_q, ready_d;
  logic        do_accept, do_release;
  instr_type_e in_type;
  logic        in_illegal;

  opcode_classify u_classify (
    .instr   (bus.in_instr),
    .itype   (in_type),
    .illegal (in_illegal)
  );

  always_comb begin
    entry_in.instr   = bus.in_instr;
    entry_in.pc      = bus.in_pc;
    entry_in.itype   = in_type;
    entry_in.rs1     = bus.in_instr[19:15];
    entry_in.rs2     = bus.in_instr[24:20];
    entry_in.rd      = bus.in_instr[11:7];
    entry_in.illegal = in_illegal;
  end

  assign do_accept  = bus.in_valid & in_ready_q;
  assign do_release = (state_q != EMPTY) & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= RESET_ENTRY;
      skid_q <= RESET_ENTRY;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Flush overrides everything but leaves the head data in place so the
  // sign extender keeps seeing a stable word while out_valid is low.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (do_accept) begin
          state_d = ONE;
          head_d  = entry_in;
        end
      end
      ONE: begin
        if (do_accept && do_release) begin
          head_d = entry_in;
        end else if (do_accept) begin
          state_d = TWO;
          skid_d  = entry_in;
        end else if (do_release) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (do_release) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end
    ready_d = (state_d != TWO);
`ifdef DECODE_ILLEGAL_TRAP_EN
    if ((state_d != EMPTY) && head_d.illegal) begin
      ready_d = 1'b0;
    end
`endif
  end

  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = (state_q != EMPTY);
    bus.out_instr = head_q.instr;
    bus.out_pc    = head_q.pc;
    bus.out_type  = head_q.itype;
    bus.out_rs1   = head_q.rs1;
    bus.out_rs2   = head_q.rs2;
    bus.out_rd    = head_q.rd;
`ifdef DECODE_ILLEGAL_TRAP_EN
    bus.out_illegal = head_q.illegal;
`else
    bus.out_illegal = 1'b0;
`endif
  end

`ifndef DECODE_ILLEGAL_TRAP_EN
  logic unused_illegal;
  assign unused_illegal = head_q.illegal;
`endif

endmodule

// File: tb/tb_decode_skid_stage.sv
// Scoreboard bench for decode_skid_stage: directed scenarios plus random traffic
// against an in-order queue model of the held instructions.
module tb_decode_skid_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP_I  = 32'h0000_0013;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  itype;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          compared   = 0;
  int          mismatched = 0;
  exp_t        expq[$];
  logic [31:0] pc_ctr = 32'h0000_0100;

  always #5 clk = ~clk;

  decode_skid_stage_if #(.XLEN(32)) bus ();

  decode_skid_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic exp_t refModel(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    logic [6:0] op;
    op = instr[6:0];
    e.instr = instr;
    e.pc    = pc;
    e.rs1   = instr[19:15];
    e.rs2   = instr[24:20];
    e.rd    = instr[11:7];
    e.illegal = 1'b0;
    case (op)
      7'h33:                             e.itype = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: e.itype = 3'd1;
      7'h23:                             e.itype = 3'd2;
      7'h63:                             e.itype = 3'd3;
      7'h37, 7'h17:                      e.itype = 3'd4;
      7'h6F:                             e.itype = 3'd5;
      default: begin
        e.itype   = 3'd0;
        e.illegal = TRAP;
      end
    endcase
    return e;
  endfunction

  function automatic logic expReady();
    if (expq.size() >= 2) return 1'b0;
    if (TRAP && expq.size() > 0 && expq[0].illegal) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops[12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                            7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: checks handshake outputs every cycle and pops the scoreboard on release.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      checkOutput("out_valid", 32'(bus.out_valid), 32'(expq.size() > 0));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady()));
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_release: got instr %h required none", bus.out_instr);
        end else begin
          e = expq.pop_front();
          checkOutput("out_instr", bus.out_instr, e.instr);
          checkOutput("out_pc", bus.out_pc, e.pc);
          checkOutput("out_type", 32'(bus.out_type), 32'(e.itype));
          checkOutput("out_rs1", 32'(bus.out_rs1), 32'(e.rs1));
          checkOutput("out_rs2", 32'(bus.out_rs2), 32'(e.rs2));
          checkOutput("out_rd", 32'(bus.out_rd), 32'(e.rd));
          checkOutput("out_illegal", 32'(bus.out_illegal), 32'(e.illegal));
        end
      end
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic ordy, input logic fl, output logic acc);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(negedge clk);
    #1;
    acc = v && bus.in_ready && !fl && rst_n;
    if (rst_n && fl) expq.delete();
    else if (acc) expq.push_back(refModel(instr, pc));
    @(posedge clk);
    #1;
  endtask

  task automatic sendOne(input logic [31:0] instr, input logic ordy);
    logic acc;
    int   n;
    n = 0;
    do begin
      applyStimulus(1'b1, instr, pc_ctr, ordy, 1'b0, acc);
      n++;
    end while (!acc && n < 30);
    if (!acc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: instr %h not accepted, required accept within 30 cycles", instr);
    end
    pc_ctr += 4;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (expq.size() > 0 && n < 40) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      n++;
    end
    if (expq.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d entries left, required 0", expq.size());
    end
  endtask

  logic [31:0] stream[5] = '{32'h00500093, 32'h00112023, 32'hFE000EE3, 32'h000012B7, 32'h008000EF};

  initial begin
    logic        acc, got, v, ordy, fl;
    logic [31:0] instr, pc;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_instr", bus.out_instr, NOP_I);
    checkOutput("rst_out_pc", bus.out_pc, RST_PC);
    checkOutput("rst_out_type", 32'(bus.out_type), 32'd1);
    checkOutput("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    checkOutput("rst_rd", 32'(bus.out_rd), 32'd0);

    foreach (stream[i]) sendOne(stream[i], 1'b1);
    drain();

    // Backpressure: third instruction must wait in fetch until the skid drains.
    sendOne(32'h00A00113, 1'b0);
    sendOne(32'h00B00193, 1'b0);
    repeat (3) begin
      applyStimulus(1'b1, 32'h00C00213, pc_ctr, 1'b0, 1'b0, acc);
      checkOutput("bp_held", 32'(acc), 32'd0);
    end
    sendOne(32'h00C00213, 1'b1);
    drain();

    // Flush while full, with a same-cycle instruction that must be dropped.
    sendOne(32'h00D00293, 1'b0);
    pc = pc_ctr - 4;
    sendOne(32'h00E00313, 1'b0);
    applyStimulus(1'b1, 32'h00F00393, pc_ctr, 1'b0, 1'b1, acc);
    checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_keep_instr", bus.out_instr, 32'h00D00293);
    checkOutput("flush_keep_pc", bus.out_pc, pc);
    repeat (2) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // Illegal opcode at head.
    sendOne(32'h0000007F, 1'b0);
    checkOutput("illegal_flag", 32'(bus.out_illegal), 32'(TRAP));
    checkOutput("illegal_type", 32'(bus.out_type), 32'd0);
    got = 1'b0;
    repeat (3) begin
      if (!got) begin
        applyStimulus(1'b1, 32'h01000413, pc_ctr, 1'b0, 1'b0, acc);
        got = acc;
      end
    end
    checkOutput("illegal_block", 32'(got), 32'(!TRAP));
    if (got) pc_ctr += 4;
    else sendOne(32'h01000413, 1'b1);
    drain();

    // Accept and release together in ONE.
    sendOne(32'h01100493, 1'b0);
    applyStimulus(1'b1, 32'h01200513, pc_ctr, 1'b1, 1'b0, acc);
    pc_ctr += 4;
    checkOutput("simul_accept", 32'(acc), 32'd1);
    checkOutput("simul_head", bus.out_instr, 32'h01200513);
    drain();

    // Random traffic; fetch holds an unaccepted instruction.
    v = 1'b0; instr = randInstr();
    for (int c = 0; c < 1500; c++) begin
      if (!(v && !acc) || fl) begin
        instr = randInstr();
        v = ($urandom_range(0, 9) < 7);
      end
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 29) == 0);
      applyStimulus(v, instr, pc_ctr, ordy, fl, acc);
      if (acc) pc_ctr += 4;
    end
    drain();

    // Reset while two entries are held.
    sendOne(32'h01300593, 1'b0);
    sendOne(32'h01400613, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    expq.delete();
    #1;
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_instr", bus.out_instr, NOP_I);
    checkOutput("midrst_pc", bus.out_pc, RST_PC);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sendOne(32'h01500693, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_skid_stage.md
Name: decode_skid_stage

Overview:
- IF/ID stage between instruction fetch and the immediate sign extender / register-file read.
- Accepts fetched instruction+PC over valid/ready and classifies the opcode into the 3-bit instr_type code consumed by the sign extender.
- Extracts rs1/rs2/rd and holds results in a 2-entry skid buffer, so in_ready is a registered signal with no combinational ready path from downstream to fetch.

Parameters:
- XLEN, 32, instruction and PC width.
- RESET_PC, 32'h0000_0000, value driven on out_pc while empty after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  XLEN  fetched instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  branch/jump redirect; discards all held entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_instr  out  XLEN  head instruction, passed to sign extender.
- out_pc  out  XLEN  head PC.
- out_type  out  3  000 R/none, 001 I, 010 S, 011 B, 100 U, 101 J.
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7].
- out_illegal  out  1  head opcode unrecognised.

Behaviour:
- Reset (async assert, sync deassert by caller):
  - state EMPTY; out_valid=0; in_ready=1; out_instr=32'h0000_0013 (NOP); out_pc=RESET_PC; out_type=001; out_illegal=0; rs/rd=0.
- Classification on in_instr[6:0], registered with the entry:
  - 0110011 → 000.
  - 0010011, 0000011, 1100111, 1110011, 0001111 → 001.
  - 0100011 → 010.
  - 1100011 → 011.
  - 0110111, 0010111 → 100.
  - 1101111 → 101.
  - Other → 000 with illegal=1.
- Transfers: accept = in_valid & in_ready; release = out_valid & out_ready. Latency is 1 cycle, accept edge to out_valid.
- States: EMPTY (0 entries), ONE (head only), TWO (head + skid).
  - EMPTY: accept → ONE (head loaded).
  - ONE:
    - accept & release → ONE (head replaced).
    - accept only → TWO (skid loaded).
    - release only → EMPTY.
  - TWO: in_ready=0. release → ONE with skid moved to head.
- in_ready = (state != TWO), registered from next state.
- Outputs drive directly from the head register.
- out_instr and classification fields are held stable while out_valid & !out_ready.
- flush:
  - Next state EMPTY and both entries invalidated, regardless of a simultaneous accept or release.
  - An instruction presented in the flush cycle is dropped.
  - out_instr/out_pc keep their last value, but out_valid=0.
- Reset mid-operation: entries lost immediately; no partial output.
- No combinational path from in_* or out_ready to any output.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - out_illegal is asserted as above.
  - An illegal entry reaching head blocks further accepts until released: in_ready=0 while head is illegal, so a trap can be taken before younger instructions enter.
  - flush clears the block.
- Undefined:
  - out_illegal is tied 0.
  - Illegal opcodes are passed as type 000 with no accept blocking.

Decomposition:
- Package rv_decode_pkg:
  - instr_type_e enum (R_NONE=3'b000, I_T=3'b001, S_T=3'b010, B_T=3'b011, U_T=3'b100, J_T=3'b101).
  - Opcode localparams (OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_FENCE).
  - NOP constant.
  - dec_entry_t struct {instr, pc, itype, rs1, rs2, rd, illegal}.
  - skid_state_e enum.
- One sub-module, opcode_classify: combinational, takes instr and returns itype and illegal. It is instantiated once on the input path so entries store pre-classified results.

Test Plan:
- Reset check: rst_n low mid-stream with two entries held → out_valid=0, in_ready=1, out_instr=32'h00000013 asynchronously.
- Streaming: out_ready=1, in_valid=1, send 0x00500093 (addi), 0x00112023 (sw), 0xFE000EE3 (beq), 0x000012B7 (lui), 0x008000EF (jal) → appear one cycle later in order with out_type 001,010,011,100,101; rd/rs fields correct.
- Backpressure: out_ready=0, send 3 instructions → first at head, second in skid, in_ready=0 the cycle after second accept; third held by fetch. Raise out_ready → order 1,2,3 with no loss or duplication.
- Flush: flush in TWO state with in_valid=1 → next cycle out_valid=0, in_ready=1; flushed and same-cycle instructions never appear.
- Illegal opcode: 0x0000007F with the macro defined → out_illegal=1, out_type=000, in_ready=0 until release. Same stimulus without the macro → out_illegal=0, no blocking.
- Simultaneous: in ONE state, accept & release in the same cycle → remains ONE, new head appears, in_ready stays 1.
